// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: buffers one vector, runs each element through the shared
// exp CORDIC while accumulating the sum, then normalises each exp via the divide CORDIC.
module softmax_seq_ctrl #(
  parameter int N     = 16,
  parameter int NNEW  = N + 6,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [N-1:0]    in_data,
  input  logic                   in_last,
  output logic                   exp_start,
  output logic signed [N-1:0]    exp_arg,
  input  logic                   exp_done,
  input  logic [NNEW-1:0]        exp_result,
  output logic                   div_start,
  output logic [NNEW-1:0]        div_num,
  output logic [NNEW-1:0]        div_den,
  input  logic                   div_done,
  input  logic [N-1:0]           div_quot,
  output logic                   capture_div,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, EXP_ISSUE, EXP_WAIT, DIV_ISSUE, DIV_WAIT, OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NNEW-1:0]         sum_q, sum_d;
  logic                    err_q, err_d;
  logic                    cap_q, cap_d;
  logic                    edone_q, edone_d;
  logic [NNEW-1:0]         eres_q, eres_d;
  logic [N-1:0]            quot_q, quot_d;
  logic signed [N-1:0]     xbuf_q [DEPTH];
  logic signed [N-1:0]     xbuf_d [DEPTH];
  logic [NNEW-1:0]         ebuf_q [DEPTH];
  logic [NNEW-1:0]         ebuf_d [DEPTH];

  logic [CW-1:0]           idx_nx;
  logic [NNEW:0]           acc;
  logic                    is_last;
  logic                    sum_nz;

  // Top bit flags saturation; the sum clamps at all-ones.
  function automatic logic [NNEW:0] sat_add(input logic [NNEW-1:0] a,
                                            input logic [NNEW-1:0] b);
    logic [NNEW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[NNEW]) return {1'b1, {NNEW{1'b1}}};
    return s;
  endfunction

  assign idx_nx  = CW'(idx_q) + CW'(1);
  assign is_last = (CW'(idx_q) == cnt_q - CW'(1));
  assign sum_nz  = (sum_q != '0);
  assign acc     = sat_add(sum_q, eres_q);

  // Control state: async reset only on control/handshake flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      cap_q   <= 1'b0;
      edone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      edone_q <= edone_d;
    end
  end

  always_ff @(posedge clk) begin
    eres_q <= eres_d;
    quot_q <= quot_d;
    xbuf_q <= xbuf_d;
    ebuf_q <= ebuf_d;
  end

  // The exp result is registered once so accumulation has its own cycle;
  // a done coincident with the start cycle is outside EXP_WAIT and dropped.
  always_comb begin
    edone_d = (state_q == EXP_WAIT) && exp_done && !edone_q;
    eres_d  = (state_q == EXP_WAIT && exp_done) ? exp_result : eres_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    err_d   = err_q;
    cap_d   = 1'b0;
    quot_d  = quot_q;
    xbuf_d  = xbuf_q;
    ebuf_d  = ebuf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xbuf_d[0] = in_data;
          cnt_d     = CW'(1);
          idx_d     = '0;
          sum_d     = '0;
          err_d     = 1'b0;
          state_d   = in_last ? EXP_ISSUE : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          xbuf_d[cnt_q[IW-1:0]] = in_data;
          cnt_d = cnt_q + CW'(1);
          if (in_last) begin
            state_d = EXP_ISSUE;
          end else if (cnt_q + CW'(1) == CW'(DEPTH)) begin
            // Vector truncated; the remaining elements start the next vector.
            err_d   = 1'b1;
            state_d = EXP_ISSUE;
          end
        end
      end
      EXP_ISSUE: state_d = EXP_WAIT;
      EXP_WAIT: begin
        if (edone_q) begin
          ebuf_d[idx_q] = eres_q;
          sum_d         = acc[NNEW-1:0];
          if (acc[NNEW]) err_d = 1'b1;
          if (idx_nx < cnt_q) begin
            idx_d   = idx_nx[IW-1:0];
            state_d = EXP_ISSUE;
          end else begin
            idx_d   = '0;
            state_d = DIV_ISSUE;
          end
        end
      end
      DIV_ISSUE: begin
        if (sum_nz) begin
          state_d = DIV_WAIT;
        end else begin
          quot_d  = '0;
          cap_d   = 1'b1;
          state_d = OUT;
        end
      end
      DIV_WAIT: begin
        if (div_done) begin
          quot_d  = div_quot;
          cap_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (is_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_nx[IW-1:0];
            state_d = DIV_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data outputs are forced to zero outside the states that own them.
  always_comb begin
    in_ready    = (state_q == IDLE) || (state_q == LOAD);
    exp_start   = (state_q == EXP_ISSUE);
    exp_arg     = (state_q == EXP_ISSUE || state_q == EXP_WAIT) ? xbuf_q[idx_q] : '0;
    div_start   = (state_q == DIV_ISSUE) && sum_nz;
    div_num     = '0;
    div_den     = '0;
    if ((state_q == DIV_ISSUE && sum_nz) || state_q == DIV_WAIT) begin
      div_num = ebuf_q[idx_q];
      div_den = sum_q;
    end
    capture_div = cap_q;
    out_valid   = (state_q == OUT);
    out_data    = (state_q == OUT) ? quot_q : '0;
    out_last    = (state_q == OUT) && is_last;
    busy        = (state_q != IDLE);
    err         = err_q;
  end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl with behavioural exp/div CORDIC stubs.
module tb_softmax_seq_ctrl;
  localparam int N = 16, NNEW = 22, DEPTH = 8, LEXP = 16, LDIV = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic in_valid, in_ready, in_last;
  logic signed [N-1:0] in_data, exp_arg;
  logic exp_start, exp_done, div_start, div_done, capture_div;
  logic [NNEW-1:0] exp_result, div_num, div_den;
  logic [N-1:0] div_quot, out_data;
  logic out_valid, out_ready, out_last, busy, err;

  softmax_seq_ctrl #(.N(N), .NNEW(NNEW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .exp_start(exp_start), .exp_arg(exp_arg), .exp_done(exp_done), .exp_result(exp_result),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_quot(div_quot), .capture_div(capture_div),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  typedef struct packed { logic [N-1:0] d; logic l; } exp_t;
  exp_t sb[$];
  int nchk = 0, npass = 0;
  int n_out = 0, n_exp = 0, n_div = 0, n_cap = 0;
  logic [NNEW-1:0] exp_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: the handshake completes on the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 64'(out_data), 64'hdead);
      else begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_last", 64'(out_last), 64'(e.l));
      end
      n_out++;
    end
  end

  always @(negedge clk) begin
    if (exp_start) n_exp++;
    if (div_start) n_div++;
    if (capture_div) n_cap++;
  end

  initial begin
    exp_done = 1'b0; exp_result = '0;
    forever begin
      @(negedge clk);
      if (exp_start) begin
        repeat (LEXP) @(posedge clk);
        #1 exp_done = 1'b1; exp_result = exp_val;
        @(posedge clk);
        #1 exp_done = 1'b0; exp_result = '0;
      end
    end
  end

  initial begin
    logic [NNEW-1:0] dn, dd;
    div_done = 1'b0; div_quot = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        dn = div_num; dd = div_den;
        repeat (LDIV) @(posedge clk);
        #1 div_done = 1'b1;
        div_quot = (dd == '0) ? '0 : N'((longint'(dn) << 14) / longint'(dd));
        @(posedge clk);
        #1 div_done = 1'b0; div_quot = '0;
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 3000) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push(input logic [N-1:0] d, input logic l);
    sb.push_back('{d: d, l: l});
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 5000) begin @(posedge clk); #1; t++; end
    chk(name, 64'(sb.size() == 0 && !busy), 64'd1);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!out_valid && t < 2000) begin @(posedge clk); #1; t++; end
    chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic clr();
    n_out = 0; n_exp = 0; n_div = 0; n_cap = 0;
  endtask

  initial begin
    int t;
    logic [N-1:0] d0;
    int nd0, ne0, no0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ctrl", 64'({busy, exp_start, div_start, capture_div, out_valid, out_last, err}), 64'd0);
    chk("rst_data_a", 64'({exp_arg, out_data}), 64'd0);
    chk("rst_data_b", 64'({div_num, div_den}), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Four equal exps: each output is one quarter.
    clr(); exp_val = 22'h01000;
    for (int i = 0; i < 4; i++) push(16'h1000, i == 3);
    send(16'h0100, 0); send(16'hFF00, 0); send(16'h0000, 0); send(16'h2000, 1);
    chk("exp_start_after_last", 64'(exp_start), 64'd1);
    wait_drain("t1_drain");
    chk("t1_capture_cnt", 64'(n_cap), 64'd4);
    chk("t1_exp_cnt", 64'(n_exp), 64'd4);
    chk("t1_div_cnt", 64'(n_div), 64'd4);
    chk("t1_err", 64'(err), 64'd0);

    // Single element normalises to 1.0; busy drops right after the handshake.
    clr(); exp_val = 22'h00800;
    push(16'h4000, 1);
    send(16'h0000, 1);
    wait_out_valid();
    @(posedge clk); #1;
    chk("t2_busy_fall", 64'(busy), 64'd0);
    wait_drain("t2_drain");

    // Nine elements, no in_last: truncation at DEPTH, ninth starts a new vector.
    clr(); exp_val = 22'h01000;
    for (int i = 0; i < 8; i++) push(16'h0800, i == 7);
    for (int i = 0; i < 8; i++) send(16'(i * 16), 0);
    wait_drain("t3_drain");
    chk("t3_err_set", 64'(err), 64'd1);
    chk("t3_out_cnt", 64'(n_out), 64'd8);
    push(16'h4000, 1);
    send(16'h0123, 1);
    chk("t3_err_clear", 64'(err), 64'd0);
    wait_drain("t3_drain2");

    // All exps zero: no divides, zero outputs, capture still pulses.
    clr(); exp_val = 22'h0;
    for (int i = 0; i < 3; i++) push(16'h0000, i == 2);
    send(16'h8000, 0); send(16'h8000, 0); send(16'h8000, 1);
    wait_drain("t4_drain");
    chk("t4_div_cnt", 64'(n_div), 64'd0);
    chk("t4_capture_cnt", 64'(n_cap), 64'd3);

    // Output stall on the second element.
    clr(); exp_val = 22'h01000;
    for (int i = 0; i < 3; i++) push(16'h1555, i == 2);
    send(16'h0010, 0); send(16'h0020, 0); send(16'h0030, 1);
    t = 0;
    while (n_out < 1 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("t5_first_out", 64'(n_out), 64'd1);
    out_ready = 1'b0;
    wait_out_valid();
    d0 = out_data; nd0 = n_div;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t5_stall_data", 64'(out_data), 64'(d0));
      chk("t5_stall_valid", 64'(out_valid), 64'd1);
    end
    chk("t5_no_div_start", 64'(n_div), 64'(nd0));
    out_ready = 1'b1;
    wait_drain("t5_drain");

    // Reset during EXP_WAIT of the second element.
    clr(); exp_val = 22'h01000;
    send(16'h0111, 0); send(16'h0222, 0); send(16'h0333, 1);
    t = 0;
    while (n_exp < 2 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("t6_reached_exp2", 64'(n_exp), 64'd2);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_ctrl", 64'({busy, exp_start, div_start, capture_div, out_valid, out_last, err}), 64'd0);
    chk("t6_rst_data", 64'({exp_arg, out_data}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ne0 = n_exp; nd0 = n_div; no0 = n_out;
    repeat (30) @(posedge clk); #1;
    chk("t6_quiet_exp", 64'(n_exp), 64'(ne0));
    chk("t6_quiet_out", 64'(n_out + n_div), 64'(no0 + nd0));
    push(16'h2000, 0); push(16'h2000, 1);
    send(16'h0444, 0); send(16'h0555, 1);
    wait_drain("t6_drain");

    // Sum saturation: 2 * 0x200000 clamps to 0x3FFFFF and flags err.
    clr(); exp_val = 22'h200000;
    push(16'h2000, 0); push(16'h2000, 1);
    send(16'h1000, 0); send(16'h1000, 1);
    wait_drain("t7_drain");
    chk("t7_err_sat", 64'(err), 64'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/softmax_seq_ctrl.md
# softmax_seq_ctrl

Sequencer that runs one softmax vector through the shared CORDIC datapath. It buffers up to DEPTH input elements and issues each one to the hyperbolic (exp) CORDIC while accumulating the sum. It then issues each exp value to the linear (divide) CORDIC against that sum and streams out the normalised results. It sits between the input stream and the CORDIC exp/div units inside the softmax top.

## Interface
- N, 16, element/quotient width (signed Q2.(N-2) in, unsigned Q2.(N-2) out)
- NNEW, N+6, exp result / sum / divider operand width
- DEPTH, 8, max vector length (power of 2, ≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid / in_ready  input / output  1  input handshake
- in_data  input  N  element x_i
- in_last  input  1  marks final element of vector
- exp_start  output  1  one-cycle pulse, launch exp CORDIC
- exp_arg  output  N  argument for exp, held from start until done
- exp_done  input  1  exp CORDIC result valid (one cycle)
- exp_result  input  NNEW  e^x_i, unsigned
- div_start  output  1  one-cycle pulse, launch divide CORDIC
- div_num, div_den  output  NNEW each  dividend e^x_i, divisor sum; held until div_done
- div_done  input  1  quotient valid (one cycle)
- div_quot  input  N  quotient
- capture_div  output  1  one-cycle pulse when div_quot is latched
- out_valid / out_ready  output / input  1  output handshake
- out_data  output  N  softmax element
- out_last  output  1  with final output element
- busy  output  1  state ≠ IDLE
- err  output  1  sticky: truncation or sum saturation; cleared on next vector's first accept

## Operation
- States: IDLE, LOAD, EXP_ISSUE, EXP_WAIT, DIV_ISSUE, DIV_WAIT, OUT.
- IDLE: in_ready=1. An accepted element is written to buf[0], cnt=1, sum=0, err=0. Next state is LOAD, or EXP_ISSUE if in_last.
- LOAD: in_ready=1. Accept into buf[cnt] and increment cnt. Leave on in_last, or when cnt reaches DEPTH. In the DEPTH case without in_last, set err; the following elements belong to the next vector.
- EXP_ISSUE (1 cycle): exp_start=1, exp_arg=buf[idx]. Then EXP_WAIT.
- EXP_WAIT: on exp_done, ebuf[idx]=exp_result and sum=sum+exp_result.
  - The sum saturates at 2^NNEW-1; saturation sets err.
  - idx+1<cnt → EXP_ISSUE; otherwise idx=0 → DIV_ISSUE.
- DIV_ISSUE (1 cycle):
  - If sum≠0: div_start=1, div_num=ebuf[idx], div_den=sum, then DIV_WAIT.
  - If sum==0: no start; q=0 and go directly to OUT. capture_div still pulses.
- DIV_WAIT: on div_done, q=div_quot, capture_div=1 for that cycle, then OUT.
- OUT: out_valid=1, out_data=q, out_last=(idx==cnt-1). On out_ready: if last → IDLE, else idx+1 → DIV_ISSUE.
- exp_done / div_done are ignored outside their WAIT states.
- in_ready=0 in all states except IDLE/LOAD.

## Timing
- Reset (asserted low, async): state=IDLE, cnt=idx=0, sum=0.
  - All outputs 0 except in_ready=1. This includes exp_start, div_start, capture_div, out_valid, out_last, busy, err and all data outputs.
  - Buffer contents are don't-care.
- Reset mid-operation aborts the vector immediately. No start pulse or out_valid after release until a new vector arrives.
- Last element accepted at edge T → exp_start high in cycle T+1.
- exp_done at edge T → next exp_start at T+2. After the last exp, div_start (or the sum==0 OUT entry) follows at T+2.
- div_done at edge T → capture_div and out_valid both high from T+1; out_valid stays until out_ready.
- exp_start/div_start are never asserted while the corresponding unit is still running (at most one outstanding op per unit).
- exp_done coincident with its own start cycle is ignored.
- out_data/out_last are stable while out_valid && !out_ready.
- Per vector cycles ≈ cnt·(2+Lexp) + cnt·(2+Ldiv) + output stalls.

## Test plan
- 4-element vector, exp stub returns 0x01000 each after 16 cycles, div stub returns num·2^14/den → sum=0x04000, four outputs 0x1000, out_last on 4th, capture_div pulsed 4 times.
- Single element with in_last, exp 0x00800 → one output 0x4000 (1.0), busy falls the cycle after handshake.
- 9 elements without in_last at DEPTH=8 → first 8 processed, err=1, 9th accepted as first of next vector (err cleared on that accept).
- Exp stub returns 0 for all → no div_start, outputs 0x0000, capture_div still pulses per element.
- out_ready held low 10 cycles on 2nd output → out_data stable, no div_start issued until handshake.
- reset pulled low during EXP_WAIT of element 2 → all outputs 0 immediately; after release a new 2-element vector completes correctly with sum from 0.
